// File: rtl/nodesplit_rtl.sv
`default_nettype none
// ============================================================================
//  Module      : nodesplit_rtl
//  Description : 1-to-4 split node. A data token and a control token are
//                joined and the data is routed to the output port chosen by
//                ctrl_data[1:0]. Each output port owns a one-entry register,
//                so a stalled port only blocks tokens addressed to it.
//  Options     : NODESPLIT_BROADCAST_EN - ctrl_data[2]=1 copies the data
//                into all four ports (BCAST state).
//  Revision    : 1.0 - initial release
// ============================================================================
module nodesplit_rtl #(
  parameter int W  = 11,
  parameter int CW = 3
) (
  input  logic           CLK,
  input  logic           _RESET,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [CW-1:0]  ctrl_data,
  input  logic           ctrl_valid,
  output logic           ctrl_ready,
  output logic [4*W-1:0] out_data,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready
);

`ifdef NODESPLIT_BROADCAST_EN
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BCAST = 1'b1
  } state_t;
`else
  typedef enum logic [0:0] {
    IDLE = 1'b0
  } state_t;
`endif

  state_t     state;
  state_t     state_next;
  logic       run;
  logic [1:0] sel;
  logic [3:0] slot_free;
  logic [3:0] load;
  logic       fire;
  logic       unused_ctrl;

  assign sel       = ctrl_data[1:0];
  // A slot that is draining on this edge can take a new token on the same edge.
  assign slot_free = ~out_valid | out_ready;
  // Upper control bits only matter when broadcast is built in.
  assign unused_ctrl = ^ctrl_data[CW-1:2];

  // Data and control are consumed together or not at all.
  assign in_ready   = fire;
  assign ctrl_ready = fire;

  // Holds off consumption until the first edge after reset release.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) run <= 1'b0;
    else         run <= 1'b1;
  end

  // State register.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) state <= IDLE;
    else         state <= state_next;
  end

  // Join decision, slot load selection and next-state logic.
  always_comb begin
    fire       = 1'b0;
    load       = 4'b0000;
    state_next = state;
`ifdef NODESPLIT_BROADCAST_EN
    if (state == IDLE) begin
      if (ctrl_data[2]) begin
        if (run && in_valid && ctrl_valid && (&slot_free)) begin
          fire       = 1'b1;
          load       = 4'b1111;
          state_next = BCAST;
        end
      end else if (run && in_valid && ctrl_valid && slot_free[sel]) begin
        fire      = 1'b1;
        load[sel] = 1'b1;
      end
    end else begin
      // Only broadcast copies can be pending here; leave once all are taken.
      if ((out_valid & ~out_ready) == 4'b0000) state_next = IDLE;
    end
`else
    if (run && in_valid && ctrl_valid && slot_free[sel]) begin
      fire      = 1'b1;
      load[sel] = 1'b1;
    end
`endif
  end

  // Per-port one-entry output registers; load wins over drain on the same edge.
  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      out_valid <= 4'b0000;
      out_data  <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (load[k]) begin
          out_valid[k]        <= 1'b1;
          out_data[k*W +: W]  <= in_data;
        end else if (out_ready[k]) begin
          out_valid[k] <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
